// File: rtl/sr_strobe_gen_if.sv
// Request/strobe bundle for sr_strobe_gen.
//   master: requester + strobe consumer (drives REQ_VALID/REQ_IDX/REQ_SET)
//   slave : the strobe generator (drives REQ_READY, SO, RO, Q, BUSY, ERR)
//   REQ_VALID/REQ_READY : request handshake
//   REQ_IDX             : target SR cell index
//   REQ_SET             : 1 = set the cell, 0 = clear it
//   SO/RO               : per-cell S and R strobes, polarity set by the generator
//   Q                   : shadow copy of the SR bank
//   BUSY                : inverse of REQ_READY
//   ERR                 : one-cycle pulse on an out-of-range request
interface sr_strobe_gen_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);

  logic             REQ_VALID;
  logic             REQ_READY;
  logic [IDXW-1:0]  REQ_IDX;
  logic             REQ_SET;
  logic [WIDTH-1:0] SO;
  logic [WIDTH-1:0] RO;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic             ERR;

  modport master (
    output REQ_VALID, REQ_IDX, REQ_SET,
    input  REQ_READY, SO, RO, Q, BUSY, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_IDX, REQ_SET,
    output REQ_READY, SO, RO, Q, BUSY, ERR
  );

endinterface

// File: rtl/sr_strobe_gen.sv
// Strobe sequencer for a bank of SR cells: takes one set/clear request per
// handshake, drives a polarity-correct S or R pulse of PULSE_LEN cycles on the
// addressed cell, then holds all strobes inactive for GAP_LEN guard cycles.
// A shadow copy of the bank state is kept in Q.
//   C   : clock, rising edge
//   R   : synchronous active-high reset
//   bus : sr_strobe_gen_if slave (request handshake, SO/RO strobes, Q, BUSY, ERR)
module sr_strobe_gen #(
  parameter int unsigned      WIDTH     = 3,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter logic             S_POL     = 1'b1,
  parameter logic             R_POL     = 1'b1,
  parameter int unsigned      PULSE_LEN = 2,
  parameter int unsigned      GAP_LEN   = 1
) (
  input  logic           C,
  input  logic           R,
  sr_strobe_gen_if.slave bus
);

  localparam int unsigned IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CNTW    = (MAX_LEN > 0) ? $clog2(MAX_LEN + 1) : 1;

  // Inactive levels of the strobe vectors.
  localparam logic [WIDTH-1:0] S_IDLE = {WIDTH{~S_POL}};
  localparam logic [WIDTH-1:0] R_IDLE = {WIDTH{~R_POL}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] so_q;
  logic [WIDTH-1:0] ro_q;
  logic [WIDTH-1:0] q_q;
  logic             err_q;

  logic             ready;
  logic             accept;
  logic             idx_ok;
  logic [WIDTH-1:0] hit;

  // Handshake decode; reset priority is applied in the sequential block.
  assign ready  = (state_q == IDLE);
  assign accept = bus.REQ_VALID && ready;
  assign idx_ok = (32'(bus.REQ_IDX) < WIDTH);
  // One-hot select of the addressed cell; XOR against the idle level makes it active.
  assign hit    = idx_ok ? (WIDTH'(1) << bus.REQ_IDX) : '0;

  // Sequencer: IDLE -> PULSE (PULSE_LEN cycles) -> GAP (GAP_LEN cycles) -> IDLE.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      so_q    <= S_IDLE;
      ro_q    <= R_IDLE;
      q_q     <= INIT;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (idx_ok) begin
              state_q <= PULSE;
              cnt_q   <= CNTW'(PULSE_LEN);
              if (bus.REQ_SET) begin
                so_q <= S_IDLE ^ hit;
                q_q  <= q_q | hit;
              end else begin
                ro_q <= R_IDLE ^ hit;
                q_q  <= q_q & ~hit;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PULSE: begin
          // Last active cycle: release the strobe on this edge.
          if (cnt_q == CNTW'(1)) begin
            so_q <= S_IDLE;
            ro_q <= R_IDLE;
            if (GAP_LEN == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
              cnt_q   <= CNTW'(GAP_LEN);
            end
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CNTW'(1)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.BUSY      = ~ready;
  assign bus.SO        = so_q;
  assign bus.RO        = ro_q;
  assign bus.Q         = q_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_sr_strobe_gen.sv
// Bench for sr_strobe_gen: three configurations driven side by side, checked
// against a schedule-based reference model plus directed vectors.
module tb_sr_strobe_gen;

  localparam int unsigned W  = 3;
  localparam int unsigned IW = 2;
  localparam int          ND = 3;

  // Per-instance configuration, mirrored in the instance parameters below.
  int         p_len  [ND] = '{2, 2, 1};
  int         g_len  [ND] = '{1, 1, 0};
  logic [2:0] init_v [ND] = '{3'h0, 3'h7, 3'h0};
  logic       spol   [ND] = '{1'b1, 1'b1, 1'b0};
  logic       rpol   [ND] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [ND];
  logic          vld   [ND];
  logic [IW-1:0] idx   [ND];
  logic          set_r [ND];

  logic [W-1:0]  so_s   [ND];
  logic [W-1:0]  ro_s   [ND];
  logic [W-1:0]  q_s    [ND];
  logic          rdy_s  [ND];
  logic          busy_s [ND];
  logic          err_s  [ND];

  sr_strobe_gen_if #(.WIDTH(W), .IDXW(IW)) if0 ();
  sr_strobe_gen_if #(.WIDTH(W), .IDXW(IW)) if1 ();
  sr_strobe_gen_if #(.WIDTH(W), .IDXW(IW)) if2 ();

  sr_strobe_gen #(.WIDTH(W), .INIT(3'h0), .S_POL(1'b1), .R_POL(1'b1),
                  .PULSE_LEN(2), .GAP_LEN(1))
    u0 (.C(clk), .R(rst[0]), .bus(if0));
  sr_strobe_gen #(.WIDTH(W), .INIT(3'h7), .S_POL(1'b1), .R_POL(1'b0),
                  .PULSE_LEN(2), .GAP_LEN(1))
    u1 (.C(clk), .R(rst[1]), .bus(if1));
  sr_strobe_gen #(.WIDTH(W), .INIT(3'h0), .S_POL(1'b0), .R_POL(1'b1),
                  .PULSE_LEN(1), .GAP_LEN(0))
    u2 (.C(clk), .R(rst[2]), .bus(if2));

  assign if0.REQ_VALID = vld[0];
  assign if0.REQ_IDX   = idx[0];
  assign if0.REQ_SET   = set_r[0];
  assign if1.REQ_VALID = vld[1];
  assign if1.REQ_IDX   = idx[1];
  assign if1.REQ_SET   = set_r[1];
  assign if2.REQ_VALID = vld[2];
  assign if2.REQ_IDX   = idx[2];
  assign if2.REQ_SET   = set_r[2];

  assign so_s[0] = if0.SO;  assign ro_s[0] = if0.RO;  assign q_s[0] = if0.Q;
  assign so_s[1] = if1.SO;  assign ro_s[1] = if1.RO;  assign q_s[1] = if1.Q;
  assign so_s[2] = if2.SO;  assign ro_s[2] = if2.RO;  assign q_s[2] = if2.Q;
  assign rdy_s[0] = if0.REQ_READY; assign busy_s[0] = if0.BUSY; assign err_s[0] = if0.ERR;
  assign rdy_s[1] = if1.REQ_READY; assign busy_s[1] = if1.BUSY; assign err_s[1] = if1.ERR;
  assign rdy_s[2] = if2.REQ_READY; assign busy_s[2] = if2.BUSY; assign err_s[2] = if2.ERR;

  // Reference model: remembers the edge of the last in-range accept and derives
  // strobe window, gap and readiness from it arithmetically.
  int           e;
  int           acc_e  [ND];
  int           err_e  [ND];
  logic [W-1:0] mq     [ND];
  logic         lset   [ND];
  int           lidx   [ND];
  bit           m_acc  [ND];
  logic         pre_rdy[ND];

  int nchk;
  int nerr;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] idx;
    logic       set;
    logic [2:0] so;
    logic [2:0] ro;
    logic [2:0] q;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, d, e, act, exp);
    end
  endtask

  function automatic logic [W-1:0] s_idle(input int d);
    return spol[d] ? 3'b000 : 3'b111;
  endfunction

  function automatic logic [W-1:0] r_idle(input int d);
    return rpol[d] ? 3'b000 : 3'b111;
  endfunction

  // Apply the inputs present at edge e to the model of instance d.
  task automatic model_edge(input int d);
    bit rp;
    rp = (acc_e[d] + p_len[d] + g_len[d] <= e - 1);
    m_acc[d] = 1'b0;
    if (rst[d]) begin
      acc_e[d] = -1000;
      err_e[d] = -1000;
      mq[d]    = init_v[d];
    end else if (vld[d] && rp) begin
      m_acc[d] = 1'b1;
      if (int'(idx[d]) < int'(W)) begin
        acc_e[d]         = e;
        lset[d]          = set_r[d];
        lidx[d]          = int'(idx[d]);
        mq[d][idx[d]]    = set_r[d];
      end else begin
        err_e[d] = e;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      logic [W-1:0] xs;
      logic [W-1:0] xr;
      bit           act;
      bit           rdy;
      int           nact;
      xs   = s_idle(d);
      xr   = r_idle(d);
      act  = (e >= acc_e[d]) && (e <= acc_e[d] + p_len[d] - 1);
      rdy  = (e >= acc_e[d] + p_len[d] + g_len[d]);
      if (act) begin
        if (lset[d]) xs[lidx[d]] = ~xs[lidx[d]];
        else         xr[lidx[d]] = ~xr[lidx[d]];
      end
      check("so",   d, 32'(so_s[d]),   32'(xs));
      check("ro",   d, 32'(ro_s[d]),   32'(xr));
      check("q",    d, 32'(q_s[d]),    32'(mq[d]));
      check("err",  d, 32'(err_s[d]),  32'(err_e[d] == e));
      check("rdy",  d, 32'(rdy_s[d]),  32'(rdy));
      check("busy", d, 32'(busy_s[d]), 32'(!rdy));
      nact = $countones(so_s[d] ^ s_idle(d)) + $countones(ro_s[d] ^ r_idle(d));
      check("one_strobe", d, 32'(nact <= 1), 32'(1));
    end
  endtask

  task automatic step();
    for (int d = 0; d < ND; d++) pre_rdy[d] = rdy_s[d];
    @(posedge clk);
    #1;
    e++;
    for (int d = 0; d < ND; d++) model_edge(d);
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b0;
      vld[d] = 1'b0;
      idx[d] = '0;
      set_r[d] = 1'b0;
    end
  endtask

  initial begin
    int last;
    int nacc;

    nchk = 0;
    nerr = 0;
    e    = 0;
    for (int d = 0; d < ND; d++) begin
      acc_e[d] = -1000;
      err_e[d] = -1000;
      mq[d]    = init_v[d];
      lset[d]  = 1'b0;
      lidx[d]  = 0;
      m_acc[d] = 1'b0;
    end

    //            rst   vld   idx    set   so      ro      q       rdy   err
    tbl[0]  = '{1'b1, 1'b1, 2'd1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b1, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b010, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 1'b1, 3'b000, 3'b000, 3'b010, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b011, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 1'b1, 3'b010, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'b010, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 3'b011, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b011, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b011, 1'b1, 1'b0};

    // Bring every instance out of reset.
    idle_inputs();
    for (int d = 0; d < ND; d++) rst[d] = 1'b1;
    step();
    step();
    idle_inputs();
    step();

    // Directed vectors on the default configuration.
    for (int i = 0; i < 18; i++) begin
      rst[0]   = tbl[i].rst;
      vld[0]   = tbl[i].vld;
      idx[0]   = tbl[i].idx;
      set_r[0] = tbl[i].set;
      step();
      check("tbl_so",  i, 32'(so_s[0]),  32'(tbl[i].so));
      check("tbl_ro",  i, 32'(ro_s[0]),  32'(tbl[i].ro));
      check("tbl_q",   i, 32'(q_s[0]),   32'(tbl[i].q));
      check("tbl_rdy", i, 32'(rdy_s[0]), 32'(tbl[i].rdy));
      check("tbl_err", i, 32'(err_s[0]), 32'(tbl[i].err));
    end
    idle_inputs();

    // VALID held with alternating set/clear on idx 0: accepts 4 cycles apart.
    vld[0] = 1'b1;
    idx[0] = 2'd0;
    set_r[0] = 1'b1;
    last = -1;
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pre_rdy[0] === 1'b1) begin
        if (last >= 0) check("alt_spacing", 0, 32'(e - last), 32'(4));
        check("alt_q0", 0, 32'(q_s[0][0]), 32'(set_r[0]));
        last = e;
        nacc++;
        set_r[0] = ~set_r[0];
      end
    end
    check("alt_count", 0, 32'(nacc), 32'(5));
    idle_inputs();

    // INIT=7, active-low R: clear idx 2.
    vld[1] = 1'b1;
    idx[1] = 2'd2;
    set_r[1] = 1'b0;
    step();
    idle_inputs();
    check("neg_ro1", 1, 32'(ro_s[1]), 32'(3'b011));
    check("neg_so1", 1, 32'(so_s[1]), 32'(3'b000));
    check("neg_q",   1, 32'(q_s[1]),  32'(3'b011));
    step();
    check("neg_ro2", 1, 32'(ro_s[1]), 32'(3'b011));
    step();
    check("neg_ro3", 1, 32'(ro_s[1]), 32'(3'b111));

    // Reset in the second pulse cycle of "set idx 0"; a presented request is dropped.
    for (int i = 0; i < 4; i++) step();
    vld[0] = 1'b1;
    idx[0] = 2'd0;
    set_r[0] = 1'b1;
    step();
    check("rstmid_so_on", 0, 32'(so_s[0]), 32'(3'b001));
    vld[0] = 1'b0;
    step();
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    idx[0] = 2'd2;
    step();
    check("rstmid_so", 0, 32'(so_s[0]), 32'(3'b000));
    check("rstmid_ro", 0, 32'(ro_s[0]), 32'(3'b000));
    check("rstmid_q",  0, 32'(q_s[0]),  32'(3'b000));
    idle_inputs();
    step();
    check("rstmid_rdy", 0, 32'(rdy_s[0]), 32'(1));
    check("rstmid_so2", 0, 32'(so_s[0]), 32'(3'b000));

    // PULSE_LEN=1, GAP_LEN=0, active-low S: back-to-back accepts 2 cycles apart.
    check("nso_idle", 2, 32'(so_s[2]), 32'(3'b111));
    vld[2] = 1'b1;
    idx[2] = 2'd0;
    set_r[2] = 1'b1;
    last = -1;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pre_rdy[2] === 1'b1) begin
        if (last >= 0) check("b2b_spacing", 2, 32'(e - last), 32'(2));
        check("b2b_so", 2, 32'(so_s[2]), 32'(3'b110));
        last = e;
        nacc++;
      end else begin
        check("b2b_so_idle", 2, 32'(so_s[2]), 32'(3'b111));
      end
    end
    check("b2b_count", 2, 32'(nacc), 32'(4));
    idle_inputs();
    step();

    // Random traffic; payload held until the model sees it accepted.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < ND; d++) begin
        if (rst[d] || !vld[d] || m_acc[d]) begin
          vld[d]   = ($urandom_range(0, 2) != 0);
          idx[d]   = IW'($urandom_range(0, 3));
          set_r[d] = $urandom_range(0, 1) != 0;
        end
        rst[d] = ($urandom_range(0, 39) == 0);
      end
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
